uart_rx_framer: RTL
===================

# uart_rx_framer

Receives asynchronous serial frames (1 start bit, WIDTH data bits sent LSB first, 1 stop bit, no parity) on a single input pin. Each completed byte is delivered as a single-cycle write strobe plus data.
- Sits directly upstream of the receive FIFO: `data_out` and `wr_out` drive the FIFO's write data and write enable, and the FIFO's full flag returns on `full_in`.
- Framing errors and overruns are reported as pulses and are never written to the FIFO.

## Interface
Parameters:
- `CLK_FREQ`, default 12000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `WIDTH`, default 8: data bits per frame.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  system clock. All logic is on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rx_in`  in  1  raw serial line. It is asynchronous to `CLK` and idles high.
- `full_in`  in  1  downstream FIFO full flag.
- `data_out`  out  WIDTH  last received byte.
- `wr_out`  out  1  write strobe, one cycle wide.
- `frame_err_out`  out  1  stop bit sampled low; one-cycle pulse.
- `overrun_out`  out  1  valid byte dropped because `full_in` was high; one-cycle pulse.
- `busy_out`  out  1  high in every state except IDLE.

## Operation
- `CPB = CLK_FREQ / BAUD` (integer division; 104 at the defaults). `H = CPB / 2` (52).
  - Elaboration fails if `CPB < 4`.
- `rx_in` passes through a two-flop synchroniser; its output is `rx_s`. All decisions use `rx_s`.
- The bit counter is `$clog2(CPB)` bits wide. The bit index is `$clog2(WIDTH+1)` bits wide.
- States:
  - **IDLE**: when `rx_s == 0`, clear the counter and go to START.
  - **START**: at counter `H-1`, sample `rx_s`.
    - If 1: the start bit was a glitch; go to IDLE with no output.
    - If 0: clear the counter and index, go to DATA.
  - **DATA**: every `CPB` cycles, sample `rx_s` and shift it into the MSB of the shift register (right shift, so LSB-first data lands correctly). After WIDTH samples, go to STOP.
  - **STOP**: after `CPB` cycles, sample `rx_s`.
    - If 1 and `full_in == 0`: register the shift register into `data_out` and pulse `wr_out`.
    - If 1 and `full_in == 1`: pulse `overrun_out`. `data_out` is unchanged.
    - In both of the above cases, go to IDLE.
    - If 0: pulse `frame_err_out`, go to RECOVER.
  - **RECOVER**: wait for `rx_s == 1` (break or line held low), then go to IDLE.
- `full_in` is sampled only in the stop-sample cycle.
- `data_out` holds its value until the next successful write.
- At most one of `wr_out`, `frame_err_out`, `overrun_out` is high in any cycle.

## Timing
- Cycle 0 is the first cycle in which `rx_s` is low while in IDLE. This is 2 cycles after `rx_in` first falls, due to the synchroniser.
- Sample points:
  - start bit: cycle `H`
  - data bit i (i = 0..WIDTH-1): cycle `H + (i+1)*CPB`
  - stop bit: cycle `H + (WIDTH+1)*CPB`
- `wr_out`, `overrun_out` and `frame_err_out` are registered. They are high in the single cycle after the stop sample; `data_out` is valid in that same cycle.
- The block is in IDLE in the cycle after the stop sample (no-error case). A start bit beginning immediately after the stop bit's midpoint is therefore accepted (minimum half-bit stop tolerance).
- Reset (`rst_in == 0`) asserted at any time, including mid-frame:
  - state goes to IDLE
  - counters are cleared
  - both synchroniser flops are set to 1
  - `data_out = 0`; `wr_out`, `frame_err_out`, `overrun_out`, `busy_out` are all 0
- Deassertion of `rst_in` is synchronised externally. After reset, a line held low is treated as a start bit.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t` (IDLE, START, DATA, STOP, RECOVER)
  - function `clks_per_bit(clk_freq, baud)`, so that the future `uart_tx` uses the same rounding
- One sub-module: `bit_sync`, a 2-flop synchroniser with a reset-value parameter (1 here).
- The top level holds the FSM, the counters and the shift register.

## Test plan
Defaults throughout: `CPB = 104`, `H = 52`.
- Byte 0xA5 sent at exact baud -> exactly one `wr_out` pulse with `data_out = 0xA5`, at cycle 52 + 9*104 + 1 after `rx_s` falls; no error pulses.
- Back-to-back 0x00, 0xFF, 0x55 with minimal stop bits -> three `wr_out` pulses carrying 0x00, 0xFF, 0x55 in order.
- 20-cycle low glitch on idle line -> returns to IDLE; no output pulses; `busy_out` low again by cycle 53.
- 0x3C with stop bit driven low, line then held low 500 cycles -> one `frame_err_out` pulse and no `wr_out`; state stays in RECOVER until the line rises; a following 0x12 is received correctly.
- 0x7E sent while `full_in = 1` -> one `overrun_out` pulse, no `wr_out`, `data_out` keeps its previous value.
- `rst_in` pulsed low in the middle of data bit 4 -> all outputs 0 immediately (asynchronous); the next clean frame 0xC3 is received correctly.
- Baud skew of ±3% on 0x96 -> still received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks.
//   uart_rx_state_t : receive framer state encoding
//   clks_per_bit()  : clock cycles per serial bit. Kept here so the receiver
//                     and the future transmitter round the baud divisor
//                     identically (integer division, truncating).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } uart_rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Two-flop synchroniser for a single asynchronous level signal.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset; both flops load RESET_VAL
//   d_in     : asynchronous input
//   q_out    : synchronised output (two clk cycles of latency)
// RESET_VAL should match the idle level of the input so that leaving reset
// does not look like an edge on the line.
// -----------------------------------------------------------------------------
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain
  // into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// -----------------------------------------------------------------------------
// uart_rx_framer
// Asynchronous serial receiver: 1 start bit, WIDTH data bits LSB first,
// 1 stop bit, no parity. Each good byte is presented to the downstream FIFO
// as a one-cycle write strobe with data.
//
// Parameters
//   CLK_FREQ      : clock frequency in Hz
//   BAUD          : line rate in bit/s
//   WIDTH         : data bits per frame
// Ports
//   CLK           : system clock, rising edge
//   rst_in        : asynchronous active-low reset
//   rx_in         : raw serial line, asynchronous, idles high
//   full_in       : FIFO full flag, looked at only in the stop-sample cycle
//   data_out      : last byte written to the FIFO (held until the next write)
//   wr_out        : one-cycle FIFO write strobe
//   frame_err_out : one-cycle pulse, stop bit sampled low
//   overrun_out   : one-cycle pulse, good byte dropped because FIFO was full
//   busy_out      : high whenever the framer is not in IDLE
//
// Timing (cycle 0 = first IDLE cycle with the synchronised line low):
//   start sample at H, data bit i at H + (i+1)*CPB, stop at H + (WIDTH+1)*CPB;
//   strobes appear in the cycle after the stop sample, which is also the
//   first cycle back in IDLE, so a new start bit may follow the stop-bit
//   midpoint directly.
// -----------------------------------------------------------------------------
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int WIDTH    = 8
) (
  input  logic             CLK,
  input  logic             rst_in,
  input  logic             rx_in,
  input  logic             full_in,
  output logic [WIDTH-1:0] data_out,
  output logic             wr_out,
  output logic             frame_err_out,
  output logic             overrun_out,
  output logic             busy_out
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int H     = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

  // Below four clocks per bit the half-bit start check and the full-bit
  // sampling grid can no longer be told apart.
  if (CPB < 4) begin : g_cpb_too_small
    $error("uart_rx_framer: CLK_FREQ/BAUD must be at least 4");
  end

  // ---------------------------------------------------------------------------
  // Line synchroniser; resets to the idle level.
  // ---------------------------------------------------------------------------
  logic rx_s;

  bit_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (CLK),
    .rst_n (rst_in),
    .d_in  (rx_in),
    .q_out (rx_s)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             wr_q,    wr_d;
  logic             ferr_q,  ferr_d;
  logic             ovr_q,   ovr_d;

  // New bit enters at the MSB; after WIDTH shifts the first (LSB) bit has
  // walked down to bit 0. Built via a concatenation so WIDTH = 1 also works.
  logic [WIDTH:0]   shift_ext;
  assign shift_ext = {rx_s, shift_q};

  always_ff @(posedge CLK or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        // Mid-point of the start bit: a line that is high again was noise.
        if (cnt_q == HALF_LAST) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_ext[WIDTH:1];
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (full_in) begin
              ovr_d = 1'b1;
            end else begin
              wr_d   = 1'b1;
              data_d = shift_q;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end
      end

      RECOVER: begin
        // Line stuck low (break): only a return to idle re-arms the framer.
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out      = data_q;
  assign wr_out        = wr_q;
  assign frame_err_out = ferr_q;
  assign overrun_out   = ovr_q;
  assign busy_out      = (state_q != IDLE);

endmodule
